// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One product/quotient bit per cycle; signed ops run on magnitudes and fix the sign at completion.
module hilo_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] inA,
  input  logic [DATA_WIDTH-1:0] inB,
  input  logic                  HiWrite,
  input  logic                  LoWrite,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output logic [1:0]            dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [W-1:0]    acc_hi_q, acc_hi_d;
  logic [W-1:0]    acc_lo_q, acc_lo_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;

  logic            op_signed, a_neg, b_neg, start_div0;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, div_sh, div_diff;
  logic            div_ok;
  logic [W-1:0]    iter_hi, iter_lo;
  logic [2*W-1:0]  prod, prod_fix;

  always_comb begin
    op_signed  = ~Op[0];
    a_neg      = op_signed & inA[W-1];
    b_neg      = op_signed & inB[W-1];
    a_mag      = a_neg ? -inA : inA;
    b_mag      = b_neg ? -inB : inB;
    start_div0 = Op[1] && (inB == '0);

    // Multiply: right-shifting {acc_hi, acc_lo}, multiplier consumed from acc_lo LSB.
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    div_sh   = {acc_hi_q, acc_lo_q[W-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ok   = ~div_diff[W];

    if (is_div_q) begin
      iter_hi = div_ok ? div_diff[W-1:0] : div_sh[W-1:0];
      iter_lo = {acc_lo_q[W-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[W:1];
      iter_lo = {mul_sum[0], acc_lo_q[W-1:1]};
    end
    prod     = {iter_hi, iter_lo};
    prod_fix = neg_q ? -prod : prod;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    case (state_q)
      S_CALC: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = rem_neg_q ? -iter_hi : iter_hi;
            lo_d = neg_q ? -iter_lo : iter_lo;
          end else begin
            hi_d = prod_fix[2*W-1:W];
            lo_d = prod_fix[W-1:0];
          end
        end
      end
      default: begin
        if (HiWrite) hi_d = inA;
        if (LoWrite) lo_d = inA;
        if (Start && start_div0) begin
          state_d = S_DONE;
          dz_d    = 1'b1;
        end else if (Start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = Op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          acc_hi_d  = '0;
          acc_lo_d  = Op[1] ? a_mag : b_mag;
          opb_d     = Op[1] ? b_mag : a_mag;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. The control unit stalls PC update while Busy=1.
- Hi and Lo feed the 32-bit 2:1 write-back muxes that select between ALU/memory data and HI/LO for MFHI/MFLO.
- Also services MTHI/MTLO writes.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO register width; iteration count equals DATA_WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle request to begin operation Op on inA/inB
- Op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- inA  input  32  multiplicand / dividend (rs)
- inB  input  32  multiplier / divisor (rt)
- HiWrite  input  1  MTHI: load inA into Hi
- LoWrite  input  1  MTLO: load inA into Lo
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse: Hi/Lo hold the new result
- DivByZero  output  1  valid with Done; divide with inB=0
- Hi  output  32  HI register
- Lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE; Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0; all internal iteration registers cleared.
- States: IDLE, CALC, DONE.
  - IDLE/DONE + Start=1 -> CALC. Operands are latched and the counter is set to 0.
  - CALC -> DONE after 32 iterations (counter 0..31). Hi/Lo load on that edge.
  - DONE -> IDLE when Start=0.
- Busy=1 exactly while in CALC. Done=1 exactly while in DONE.
- Latency: Start sampled at edge t0 -> Hi/Lo updated and Done=1 after edge t0+32 -> Done falls after edge t0+33 unless restarted.
- Back-to-back: Start during DONE is accepted.
- Start while Busy=1 is ignored; no re-latch and no restart.
- Multiply:
  - Shift-add on magnitudes, one partial-product bit per cycle.
  - Result is 64-bit {Hi,Lo}.
  - Signed (MULT): operands converted to magnitude; product negated at completion if signs differ.
- Divide:
  - Restoring shift-subtract, one quotient bit per cycle. Lo=quotient, Hi=remainder.
  - Signed (DIV): quotient truncates toward zero; remainder takes dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) -> Lo=0x80000000, Hi=0x00000000, DivByZero=0.
- Divide by zero (Op=1x, inB=0):
  - IDLE/DONE -> DONE on the next edge with no CALC.
  - Done=1, DivByZero=1; Hi/Lo unchanged.
- DivByZero is 0 for every other completion and 0 whenever Done=0.
- MTHI/MTLO:
  - HiWrite/LoWrite take effect on the edge only when not Busy.
  - Ignored in CALC.
  - If asserted on the same edge as Start, the write happens; the later result overwrites it.
- Hi/Lo are held (not cleared) during CALC. They change only on completion, MTHI/MTLO or Reset.
- Reset mid-CALC aborts immediately:
  - Busy=0, Hi/Lo=0.
  - No Done pulse follows.
- Op/inA/inB changes after the Start edge do not affect the running operation.

Test Plan:
- MULTU inA=0xFFFFFFFF, inB=0x00000002, Start 1 cycle -> Busy=1 for 32 cycles; then Done=1 one cycle, Hi=0x00000001, Lo=0xFFFFFFFE, DivByZero=0.
- MULT inA=0xFFFFFFFD (-3), inB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1 (-15) at cycle 33.
- DIV inA=0xFFFFFFF9 (-7), inB=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU inA=100, inB=7 -> Lo=14, Hi=2.
- DIVU after MTHI 0x1234/MTLO 0x5678 with inB=0 -> Done and DivByZero high one cycle after Start; Hi=0x1234, Lo=0x5678 unchanged; Busy never asserts.
- MULTU 3*4 started; new Start (DIV 9/3) plus HiWrite at cycle 10 -> both ignored; result Hi=0, Lo=12 at cycle 33. Start during the Done cycle -> accepted, Busy next cycle.
- Prior Hi/Lo nonzero; Reset pulsed asynchronously (between edges) at cycle 15 of a MULT -> Busy, Hi, Lo read 0 immediately; no Done pulse in the following 40 cycles.
